// File: rtl/amplitude_hold_controller.sv
// Amplitude-good hold sequencer for the feedback path.
// Debounces low/high amplitude samples against a latched threshold with
// release hysteresis, drives hold, and escalates a long hold to a sticky fault.
//
// state    | meaning
// DISABLED | controller off, hold released, counters cleared
// GOOD     | amplitude healthy, waiting for a low sample
// PENDING  | counting consecutive low samples toward hold
// HOLD     | feedback frozen, waiting for a high sample
// RELEASE  | counting consecutive high samples toward release
// FAULT    | hold timed out, frozen until clear_fault or disable
module amplitude_hold_controller #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_AM_tdata,
  input  logic                        S_AXIS_AM_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_AMTHR_tdata,
  input  logic                        S_AXIS_AMTHR_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] hyst,
  input  logic [CNT_WIDTH-1:0]        assert_cnt,
  input  logic [CNT_WIDTH-1:0]        release_cnt,
  input  logic [CNT_WIDTH-1:0]        max_hold,
  input  logic                        enable,
  input  logic                        clear_fault,
  output logic                        hold,
  output logic                        fault,
  output logic [2:0]                  state,
  output logic [31:0]                 hold_events
);

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_GOOD     = 3'd1,
    ST_PENDING  = 3'd2,
    ST_HOLD     = 3'd3,
    ST_RELEASE  = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                      st;
  logic [AXIS_TDATA_WIDTH-1:0] thr;
  logic [CNT_WIDTH-1:0]        acnt;
  logic [CNT_WIDTH-1:0]        rcnt;
  logic [CNT_WIDTH-1:0]        htimer;

  logic [AXIS_TDATA_WIDTH:0]   rel_sum;
  logic [AXIS_TDATA_WIDTH-1:0] rel_thr;
  logic                        low;
  logic                        high;
  logic                        smp_low;
  logic                        smp_high;
  logic [CNT_WIDTH-1:0]        eff_assert;
  logic [CNT_WIDTH-1:0]        eff_release;
  logic [CNT_WIDTH-1:0]        acnt_inc;
  logic [CNT_WIDTH-1:0]        rcnt_inc;
  logic [CNT_WIDTH-1:0]        htimer_inc;
  logic                        timeout;

  assign state = st;

  // Threshold latch; the compare below sees the value from before this edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                 thr <= '0;
    else if (S_AXIS_AMTHR_tvalid) thr <= S_AXIS_AMTHR_tdata;
  end

  // Sample classification, effective debounce targets and saturating increments.
  always_comb begin
    rel_sum     = {1'b0, thr} + {1'b0, hyst};
    rel_thr     = rel_sum[AXIS_TDATA_WIDTH] ? '1 : rel_sum[AXIS_TDATA_WIDTH-1:0];
    low         = (S_AXIS_AM_tdata <= thr);
    high        = (S_AXIS_AM_tdata > rel_thr);
    smp_low     = S_AXIS_AM_tvalid && low;
    smp_high    = S_AXIS_AM_tvalid && high;
    eff_assert  = (assert_cnt == '0) ? CNT_ONE : assert_cnt;
    eff_release = (release_cnt == '0) ? CNT_ONE : release_cnt;
    acnt_inc    = (&acnt) ? acnt : acnt + CNT_ONE;
    rcnt_inc    = (&rcnt) ? rcnt : rcnt + CNT_ONE;
    htimer_inc  = (&htimer) ? htimer : htimer + CNT_ONE;
    timeout     = (max_hold != '0) && (htimer_inc >= max_hold);
  end

  // Hold sequencing FSM with registered hold/fault and event counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      st          <= ST_DISABLED;
      hold        <= 1'b0;
      fault       <= 1'b0;
      acnt        <= '0;
      rcnt        <= '0;
      htimer      <= '0;
      hold_events <= '0;
    end else if (!enable) begin
      st     <= ST_DISABLED;
      hold   <= 1'b0;
      fault  <= 1'b0;
      acnt   <= '0;
      rcnt   <= '0;
      htimer <= '0;
    end else begin
      case (st)
        ST_DISABLED: st <= ST_GOOD;
        ST_GOOD: begin
          if (smp_low) begin
            if (eff_assert <= CNT_ONE) begin
              st          <= ST_HOLD;
              hold        <= 1'b1;
              acnt        <= '0;
              htimer      <= '0;
              hold_events <= hold_events + 32'd1;
            end else begin
              st   <= ST_PENDING;
              acnt <= CNT_ONE;
            end
          end
        end
        ST_PENDING: begin
          if (smp_low) begin
            if (acnt_inc >= eff_assert) begin
              st          <= ST_HOLD;
              hold        <= 1'b1;
              acnt        <= '0;
              htimer      <= '0;
              hold_events <= hold_events + 32'd1;
            end else begin
              acnt <= acnt_inc;
            end
          end else if (S_AXIS_AM_tvalid) begin
            st   <= ST_GOOD;
            acnt <= '0;
          end
        end
        ST_HOLD: begin
          htimer <= htimer_inc;
          // A completing release takes priority over a simultaneous timeout.
          if (smp_high && (eff_release <= CNT_ONE)) begin
            st     <= ST_GOOD;
            hold   <= 1'b0;
            rcnt   <= '0;
            htimer <= '0;
          end else if (timeout) begin
            st    <= ST_FAULT;
            fault <= 1'b1;
            rcnt  <= '0;
          end else if (smp_high) begin
            st   <= ST_RELEASE;
            rcnt <= CNT_ONE;
          end
        end
        ST_RELEASE: begin
          htimer <= htimer_inc;
          if (smp_high && (rcnt_inc >= eff_release)) begin
            st     <= ST_GOOD;
            hold   <= 1'b0;
            rcnt   <= '0;
            htimer <= '0;
          end else if (timeout) begin
            st    <= ST_FAULT;
            fault <= 1'b1;
            rcnt  <= '0;
          end else if (smp_high) begin
            rcnt <= rcnt_inc;
          end else if (S_AXIS_AM_tvalid) begin
            // Falling back to HOLD keeps the timer running: hold never dropped.
            st   <= ST_HOLD;
            rcnt <= '0;
          end
        end
        ST_FAULT: begin
          if (clear_fault) begin
            st     <= ST_GOOD;
            hold   <= 1'b0;
            fault  <= 1'b0;
            htimer <= '0;
          end
        end
        default: begin
          st    <= ST_DISABLED;
          hold  <= 1'b0;
          fault <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amplitude_hold_controller.sv
// Directed bench for amplitude_hold_controller with hand-computed expectations.
module tb_amplitude_hold_controller;

  logic        aclk;
  logic        aresetn;
  logic [31:0] am_data;
  logic        am_valid;
  logic [31:0] thr_data;
  logic        thr_valid;
  logic [31:0] hyst;
  logic [15:0] assert_cnt;
  logic [15:0] release_cnt;
  logic [15:0] max_hold;
  logic        enable;
  logic        clear_fault;
  logic        hold;
  logic        fault;
  logic [2:0]  state;
  logic [31:0] hold_events;

  int n_checks = 0;
  int n_errors = 0;

  amplitude_hold_controller #(.AXIS_TDATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .S_AXIS_AM_tdata     (am_data),
    .S_AXIS_AM_tvalid    (am_valid),
    .S_AXIS_AMTHR_tdata  (thr_data),
    .S_AXIS_AMTHR_tvalid (thr_valid),
    .hyst                (hyst),
    .assert_cnt          (assert_cnt),
    .release_cnt         (release_cnt),
    .max_hold            (max_hold),
    .enable              (enable),
    .clear_fault         (clear_fault),
    .hold                (hold),
    .fault               (fault),
    .state               (state),
    .hold_events         (hold_events)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [31:0] v);
    am_data  = v;
    am_valid = 1'b1;
    tick();
    am_valid = 1'b0;
  endtask

  task automatic load_thr(input logic [31:0] v);
    thr_data  = v;
    thr_valid = 1'b1;
    tick();
    thr_valid = 1'b0;
  endtask

  initial begin
    aresetn     = 1'b0;
    am_data     = 32'd0;
    am_valid    = 1'b1;
    thr_data    = 32'd0;
    thr_valid   = 1'b0;
    hyst        = 32'd100;
    assert_cnt  = 16'd3;
    release_cnt = 16'd2;
    max_hold    = 16'd0;
    enable      = 1'b0;
    clear_fault = 1'b0;

    // Reset and idle with samples streaming
    #12;
    chk("rst_hold", {31'd0, hold}, 32'd0);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_events", hold_events, 32'd0);
    aresetn = 1'b1;
    tick(); tick(); tick();
    chk("idle_state", {29'd0, state}, 32'd0);
    chk("idle_hold", {31'd0, hold}, 32'd0);
    am_valid = 1'b0;
    enable = 1'b1;
    tick();
    chk("enable_good", {29'd0, state}, 32'd1);

    // Debounce assert: 900,900,1100,900,900,900 with thr=1000, assert_cnt=3
    load_thr(32'd1000);
    send(32'd900);  chk("deb_p1", {29'd0, state}, 32'd2);
    send(32'd900);  chk("deb_p2", {29'd0, state}, 32'd2);
    send(32'd1100); chk("deb_break", {29'd0, state}, 32'd1);
    send(32'd900);
    send(32'd900);
    tick();         chk("deb_gap_state", {29'd0, state}, 32'd2);
    chk("deb_gap_hold", {31'd0, hold}, 32'd0);
    send(32'd900);
    chk("deb_hold", {31'd0, hold}, 32'd1);
    chk("deb_state", {29'd0, state}, 32'd3);
    chk("deb_events", hold_events, 32'd1);

    // Hysteresis release: band is (1000, 1100]; release_cnt=2
    send(32'd1050); chk("hys_1050a", {29'd0, state}, 32'd3);
    send(32'd1100); chk("hys_1100", {29'd0, state}, 32'd3);
    send(32'd1150); chk("hys_rel1_state", {29'd0, state}, 32'd4);
    chk("hys_rel1_hold", {31'd0, hold}, 32'd1);
    send(32'd1050); chk("hys_back_hold", {29'd0, state}, 32'd3);
    send(32'd1150);
    send(32'd1150);
    chk("hys_rel_state", {29'd0, state}, 32'd1);
    chk("hys_rel_hold", {31'd0, hold}, 32'd0);
    chk("hys_events", hold_events, 32'd1);

    // Timeout after 50 cycles of hold; assert_cnt=0 acts as 1
    max_hold = 16'd50;
    assert_cnt = 16'd0;
    send(32'd500);
    chk("to_enter", {31'd0, hold}, 32'd1);
    chk("to_events", hold_events, 32'd2);
    am_data = 32'd500;
    am_valid = 1'b1;
    for (int i = 0; i < 49; i++) tick();
    chk("to_49_state", {29'd0, state}, 32'd3);
    chk("to_49_fault", {31'd0, fault}, 32'd0);
    tick();
    chk("to_50_state", {29'd0, state}, 32'd5);
    chk("to_50_fault", {31'd0, fault}, 32'd1);
    chk("to_50_hold", {31'd0, hold}, 32'd1);
    am_valid = 1'b0;
    tick();
    chk("to_sticky", {31'd0, fault}, 32'd1);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    chk("clr_state", {29'd0, state}, 32'd1);
    chk("clr_fault", {31'd0, fault}, 32'd0);
    chk("clr_hold", {31'd0, hold}, 32'd0);

    // Release and timeout on the same edge: release wins
    max_hold = 16'd3;
    release_cnt = 16'd1;
    send(32'd500);
    tick();
    tick();
    send(32'd2000);
    chk("race_state", {29'd0, state}, 32'd1);
    chk("race_fault", {31'd0, fault}, 32'd0);
    chk("race_events", hold_events, 32'd3);

    // Saturating release threshold: nothing can release
    max_hold = 16'd0;
    hyst = 32'h0000_0200;
    load_thr(32'hFFFF_FF00);
    send(32'h0000_0010);
    chk("sat_enter", {29'd0, state}, 32'd3);
    send(32'hFFFF_FFFF);
    chk("sat_norel", {29'd0, state}, 32'd3);
    chk("sat_hold", {31'd0, hold}, 32'd1);

    // Threshold load coincident with a sample uses the old threshold
    thr_data = 32'd100;
    thr_valid = 1'b1;
    send(32'hFFFF_FFFF);
    thr_valid = 1'b0;
    chk("thr_old_rel", {29'd0, state}, 32'd3);
    send(32'hFFFF_FFFF);
    chk("thr_new_rel", {29'd0, state}, 32'd1);
    max_hold = 16'd2;
    thr_data = 32'd5000;
    thr_valid = 1'b1;
    send(32'd1000);
    thr_valid = 1'b0;
    chk("thr_old_low", {29'd0, state}, 32'd1);
    send(32'd1000);
    chk("thr_new_low", {29'd0, state}, 32'd3);
    chk("thr_events", hold_events, 32'd5);

    // Timeout to FAULT, then disable from FAULT
    tick();
    tick();
    chk("f2_state", {29'd0, state}, 32'd5);
    enable = 1'b0;
    tick();
    chk("dis_state", {29'd0, state}, 32'd0);
    chk("dis_hold", {31'd0, hold}, 32'd0);
    chk("dis_fault", {31'd0, fault}, 32'd0);
    enable = 1'b1;
    tick();
    chk("reen_state", {29'd0, state}, 32'd1);

    // Async reset while in RELEASE with tvalid toggling
    max_hold = 16'd0;
    assert_cnt = 16'd1;
    release_cnt = 16'd3;
    send(32'd1000);
    send(32'd6000);
    chk("ar_release", {29'd0, state}, 32'd4);
    am_data = 32'd6000;
    am_valid = 1'b1;
    #2 am_valid = 1'b0;
    #1 aresetn = 1'b0;
    #1;
    chk("ar_hold", {31'd0, hold}, 32'd0);
    chk("ar_state", {29'd0, state}, 32'd0);
    chk("ar_events", hold_events, 32'd0);
    chk("ar_rcnt", {16'd0, dut.rcnt}, 32'd0);
    chk("ar_acnt", {16'd0, dut.acnt}, 32'd0);
    chk("ar_timer", {16'd0, dut.htimer}, 32'd0);
    chk("ar_thr", dut.thr, 32'd0);
    #10 aresetn = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
